id_stage: RTL

Instruction decode stage of the 32-bit in-order RISC-V (RV32I) pipeline. It sits directly downstream of instruction fetch and consumes the valid/instr/pc triple from fetch, acknowledging each accepted instruction with notify_o. It reads the register file combinationally, decodes operation, immediate and control fields, and presents one registered decode packet to the execute stage under a valid/ready handshake. It also detects load-use hazards and flushes on taken branches.

---
 rtl/id_stage_if.sv | 36 +++
 rtl/id_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Decode-to-execute packet channel: registered decode packet with valid/ready handshake.
interface id_stage_if #(
    parameter int unsigned BITSIZE = 32
);
    logic               valid_o;
    logic               ready_i;
    logic [BITSIZE-1:0] pc_o;
    logic [BITSIZE-1:0] rs1_data_o;
    logic [BITSIZE-1:0] rs2_data_o;
    logic [BITSIZE-1:0] imm_o;
    logic [4:0]         rd_o;
    logic [2:0]         funct3_o;
    logic [3:0]         alu_op_o;
    logic               alu_src_imm_o;
    logic               alu_src_pc_o;
    logic               reg_write_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               branch_o;
    logic               jump_o;
    logic               illegal_o;

    modport master (
        output valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, alu_op_o,
               alu_src_imm_o, alu_src_pc_o, reg_write_o, mem_read_o, mem_write_o,
               branch_o, jump_o, illegal_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, funct3_o, alu_op_o,
               alu_src_imm_o, alu_src_pc_o, reg_write_o, mem_read_o, mem_write_o,
               branch_o, jump_o, illegal_o,
        output ready_i
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: combinational decode of the fetch word into a single registered
// packet for execute, with load-use hazard stall and branch flush.
module id_stage #(
    parameter int unsigned BITSIZE = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               valid_i,
    input  logic [BITSIZE-1:0] instr_i,
    input  logic [BITSIZE-1:0] pc_i,
    output logic               notify_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    input  logic [BITSIZE-1:0] rs1_data_i,
    input  logic [BITSIZE-1:0] rs2_data_i,
    input  logic [4:0]         ex_rd_i,
    input  logic               ex_mem_read_i,
    input  logic               flush_i,
    id_stage_if.master         ex_if
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT   = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA   = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [BITSIZE-1:0] pc;
        logic [BITSIZE-1:0] rs1_data;
        logic [BITSIZE-1:0] rs2_data;
        logic [BITSIZE-1:0] imm;
        logic [4:0]         rd;
        logic [2:0]         funct3;
        logic [3:0]         alu_op;
        logic               alu_src_imm;
        logic               alu_src_pc;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic               illegal;
    } pkt_t;

    logic               r_valid;
    pkt_t               r_pkt;
    pkt_t               w_pkt;
    pkt_t               w_pkt_nxt;
    logic               w_valid_nxt;
    logic               w_uses_rs1;
    logic               w_uses_rs2;
    logic               w_hazard;
    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [BITSIZE-1:0] w_imm_i;
    logic [BITSIZE-1:0] w_imm_s;
    logic [BITSIZE-1:0] w_imm_b;
    logic [BITSIZE-1:0] w_imm_u;
    logic [BITSIZE-1:0] w_imm_j;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign rs1_o    = instr_i[19:15];
    assign rs2_o    = instr_i[24:20];

    assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u = {instr_i[31:12], 12'b0};
    assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Decode the fetch word into a candidate packet
    always_comb begin
        w_pkt          = '0;
        w_uses_rs1     = 1'b0;
        w_uses_rs2     = 1'b0;
        w_pkt.pc       = pc_i;
        w_pkt.rs1_data = rs1_data_i;
        w_pkt.rs2_data = rs2_data_i;
        w_pkt.rd       = instr_i[11:7];
        w_pkt.funct3   = w_funct3;
        case (w_opcode)
            OPC_OP: begin
                w_uses_rs1      = 1'b1;
                w_uses_rs2      = 1'b1;
                w_pkt.alu_op    = f3_alu(w_funct3, instr_i[30]);
                w_pkt.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                w_uses_rs1        = 1'b1;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.reg_write   = 1'b1;
                if (w_funct3 == 3'd1 || w_funct3 == 3'd5) begin
                    w_pkt.imm    = {27'b0, instr_i[24:20]};
                    w_pkt.alu_op = f3_alu(w_funct3, instr_i[30]);
                end else begin
                    w_pkt.imm    = w_imm_i;
                    w_pkt.alu_op = f3_alu(w_funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                w_uses_rs1        = 1'b1;
                w_pkt.imm         = w_imm_i;
                w_pkt.alu_op      = ALU_ADD;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.mem_read    = 1'b1;
                w_pkt.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                w_uses_rs1        = 1'b1;
                w_uses_rs2        = 1'b1;
                w_pkt.imm         = w_imm_s;
                w_pkt.alu_op      = ALU_ADD;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.mem_write   = 1'b1;
            end
            OPC_BRANCH: begin
                w_uses_rs1   = 1'b1;
                w_uses_rs2   = 1'b1;
                w_pkt.imm    = w_imm_b;
                w_pkt.alu_op = ALU_SUB;
                w_pkt.branch = 1'b1;
            end
            OPC_JALR: begin
                w_uses_rs1        = 1'b1;
                w_pkt.imm         = w_imm_i;
                w_pkt.alu_op      = ALU_ADD;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.jump        = 1'b1;
                w_pkt.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                w_pkt.imm         = w_imm_j;
                w_pkt.alu_op      = ALU_ADD;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.alu_src_pc  = 1'b1;
                w_pkt.jump        = 1'b1;
                w_pkt.reg_write   = 1'b1;
            end
            OPC_LUI: begin
                w_pkt.imm         = w_imm_u;
                w_pkt.alu_op      = ALU_PASSB;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                w_pkt.imm         = w_imm_u;
                w_pkt.alu_op      = ALU_ADD;
                w_pkt.alu_src_imm = 1'b1;
                w_pkt.alu_src_pc  = 1'b1;
                w_pkt.reg_write   = 1'b1;
            end
            default: w_pkt.illegal = 1'b1;
        endcase
        if (w_pkt.rd == 5'd0) w_pkt.reg_write = 1'b0;
    end

    assign w_hazard = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((w_uses_rs1 && ex_rd_i == rs1_o) || (w_uses_rs2 && ex_rd_i == rs2_o));
    assign notify_o = valid_i && !flush_i && !w_hazard && (!r_valid || ex_if.ready_i);

    // Next packet: flush beats load, load beats drain, otherwise hold
    always_comb begin
        w_valid_nxt = r_valid;
        w_pkt_nxt   = r_pkt;
        if (flush_i) begin
            w_valid_nxt = 1'b0;
        end else if (notify_o) begin
            w_valid_nxt = 1'b1;
            w_pkt_nxt   = w_pkt;
        end else if (ex_if.ready_i) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_valid <= 1'b0;
            r_pkt   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_pkt   <= w_pkt_nxt;
        end
    end

    assign ex_if.valid_o       = r_valid;
    assign ex_if.pc_o          = r_pkt.pc;
    assign ex_if.rs1_data_o    = r_pkt.rs1_data;
    assign ex_if.rs2_data_o    = r_pkt.rs2_data;
    assign ex_if.imm_o         = r_pkt.imm;
    assign ex_if.rd_o          = r_pkt.rd;
    assign ex_if.funct3_o      = r_pkt.funct3;
    assign ex_if.alu_op_o      = r_pkt.alu_op;
    assign ex_if.alu_src_imm_o = r_pkt.alu_src_imm;
    assign ex_if.alu_src_pc_o  = r_pkt.alu_src_pc;
    assign ex_if.reg_write_o   = r_pkt.reg_write;
    assign ex_if.mem_read_o    = r_pkt.mem_read;
    assign ex_if.mem_write_o   = r_pkt.mem_write;
    assign ex_if.branch_o      = r_pkt.branch;
    assign ex_if.jump_o        = r_pkt.jump;
    assign ex_if.illegal_o     = r_pkt.illegal;

endmodule
